// File: rtl/rv_pkg.sv
// Shared RV64 decode constants and the memory-stage FSM state type.
package rv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [0:0] {
    StIdle,
    StWait
  } mem_state_e;

endpackage

// File: rtl/pipeline_mem_stage_if.sv
// Data-memory req/ack port between the MEM stage (master) and memory (slave).
interface pipeline_mem_stage_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane alignment: store shift/strobes, load extract/extend,
// and misalign/illegal-size detection.
module mem_lane_align
  import rv_pkg::*;
(
  input  logic [2:0]  i_off,
  input  logic [2:0]  i_funct3,
  input  logic        i_is_load,
  input  logic        i_is_store,
  input  logic [63:0] i_store_data,
  input  logic [63:0] i_rdata,
  output logic [63:0] o_wdata,
  output logic [7:0]  o_wstrb,
  output logic [63:0] o_load_data,
  output logic        o_fault
);

  logic [5:0]  w_shamt;
  logic [7:0]  w_strb_base;
  logic [63:0] w_raw;
  logic        w_illegal;
  logic        w_misalign;

  always_comb begin
    w_shamt = {i_off, 3'b000};
    o_wdata = i_store_data << w_shamt;

    w_strb_base = 8'h01;
    case (i_funct3[1:0])
      2'b00:   w_strb_base = 8'h01;
      2'b01:   w_strb_base = 8'h03;
      2'b10:   w_strb_base = 8'h0f;
      default: w_strb_base = 8'hff;
    endcase
    o_wstrb = w_strb_base << i_off;

    w_raw = i_rdata >> w_shamt;
    case (i_funct3)
      F3_B:    o_load_data = {{56{w_raw[7]}}, w_raw[7:0]};
      F3_H:    o_load_data = {{48{w_raw[15]}}, w_raw[15:0]};
      F3_W:    o_load_data = {{32{w_raw[31]}}, w_raw[31:0]};
      F3_BU:   o_load_data = {56'd0, w_raw[7:0]};
      F3_HU:   o_load_data = {48'd0, w_raw[15:0]};
      F3_WU:   o_load_data = {32'd0, w_raw[31:0]};
      default: o_load_data = w_raw;
    endcase

    w_illegal = 1'b0;
    if (i_is_load) begin
      w_illegal = (i_funct3 == 3'b111);
    end else if (i_is_store) begin
      w_illegal = i_funct3[2];
    end

    // Size comes from funct3[1:0] for both signed and unsigned loads.
    case (i_funct3[1:0])
      2'b01:   w_misalign = i_off[0];
      2'b10:   w_misalign = |i_off[1:0];
      2'b11:   w_misalign = |i_off;
      default: w_misalign = 1'b0;
    endcase

    o_fault = (i_is_load | i_is_store) & (w_illegal | w_misalign);
  end

endmodule

// File: rtl/pipeline_mem_stage.sv
// RV64 memory-access stage: drives the req/ack data port, aligns lanes, and
// registers the MEM/WB boundary. Stalls upstream while an access is pending.
module pipeline_mem_stage
  import rv_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_MEM,
  input  logic [XLEN-1:0]      alu_result_MEM,
  input  logic [XLEN-1:0]      reg_data2_MEM,
  input  logic [4:0]           rd_MEM,
  input  logic [6:0]           opcode_MEM,
  input  logic [2:0]           funct3_MEM,
  pipeline_mem_stage_if.master dmem,
  output logic                 stall_MEM,
  output logic                 valid_WB,
  output logic [4:0]           rd_WB,
  output logic                 reg_write_WB,
  output logic [XLEN-1:0]      wb_data_WB,
  output logic                 mem_fault_WB
);

  localparam int unsigned CntW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(ACK_TIMEOUT);

  mem_state_e      r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;

  logic            r_valid_wb, w_valid_wb_d;
  logic [4:0]      r_rd_wb, w_rd_wb_d;
  logic            r_rw_wb, w_rw_wb_d;
  logic [XLEN-1:0] r_data_wb, w_data_wb_d;
  logic            r_fault_wb, w_fault_wb_d;

  logic            w_is_load, w_is_store, w_is_mem, w_fault;
  logic            w_mem_go, w_timeout, w_req, w_done, w_no_wb_op;
  logic [63:0]     w_wdata, w_load_data;
  logic [7:0]      w_wstrb;

  mem_lane_align u_align (
    .i_off        (alu_result_MEM[2:0]),
    .i_funct3     (funct3_MEM),
    .i_is_load    (w_is_load),
    .i_is_store   (w_is_store),
    .i_store_data (reg_data2_MEM),
    .i_rdata      (dmem.dmem_rdata),
    .o_wdata      (w_wdata),
    .o_wstrb      (w_wstrb),
    .o_load_data  (w_load_data),
    .o_fault      (w_fault)
  );

  always_comb begin
    w_is_load  = (opcode_MEM == OP_LOAD);
    w_is_store = (opcode_MEM == OP_STORE);
    w_is_mem   = w_is_load | w_is_store;
    w_no_wb_op = opcode_MEM inside {OP_BRANCH, OP_FENCE, OP_SYSTEM};
    w_mem_go   = valid_MEM & w_is_mem & ~w_fault;
    // At the timeout limit the request is dropped, so a late ack cannot complete it.
    w_timeout  = (r_state == StWait) && (r_cnt == CntMax);
    w_req      = ~reset & w_mem_go & ~w_timeout;
    w_done     = w_req & dmem.dmem_ack;
    stall_MEM  = w_req & ~dmem.dmem_ack;

    dmem.dmem_req   = w_req;
    dmem.dmem_we    = w_req & w_is_store;
    dmem.dmem_addr  = {alu_result_MEM[63:3], 3'b000};
    dmem.dmem_wdata = w_wdata;
    dmem.dmem_wstrb = (w_req & w_is_store) ? w_wstrb : 8'h00;
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    case (r_state)
      StIdle: begin
        if (w_mem_go && !dmem.dmem_ack) begin
          w_state_d = StWait;
          w_cnt_d   = '0;
        end
      end
      StWait: begin
        if (!w_mem_go || w_timeout || dmem.dmem_ack) begin
          w_state_d = StIdle;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Anything that neither completes nor faults writes a bubble.
  always_comb begin
    w_valid_wb_d = 1'b0;
    w_rd_wb_d    = 5'd0;
    w_rw_wb_d    = 1'b0;
    w_data_wb_d  = '0;
    w_fault_wb_d = 1'b0;
    if (valid_MEM) begin
      if (w_is_mem) begin
        if (w_fault || w_timeout) begin
          w_valid_wb_d = 1'b1;
          w_rd_wb_d    = rd_MEM;
          w_fault_wb_d = 1'b1;
        end else if (w_done) begin
          w_valid_wb_d = 1'b1;
          w_rd_wb_d    = rd_MEM;
          w_rw_wb_d    = w_is_load && (rd_MEM != 5'd0);
          w_data_wb_d  = w_is_load ? w_load_data : '0;
        end
      end else begin
        w_valid_wb_d = 1'b1;
        w_rd_wb_d    = rd_MEM;
        w_rw_wb_d    = (rd_MEM != 5'd0) && !w_no_wb_op;
        w_data_wb_d  = alu_result_MEM;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_valid_wb <= 1'b0;
      r_rd_wb    <= 5'd0;
      r_rw_wb    <= 1'b0;
      r_data_wb  <= '0;
      r_fault_wb <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_valid_wb <= w_valid_wb_d;
      r_rd_wb    <= w_rd_wb_d;
      r_rw_wb    <= w_rw_wb_d;
      r_data_wb  <= w_data_wb_d;
      r_fault_wb <= w_fault_wb_d;
    end
  end

  assign valid_WB     = r_valid_wb;
  assign rd_WB        = r_rd_wb;
  assign reg_write_WB = r_rw_wb;
  assign wb_data_WB   = r_data_wb;
  assign mem_fault_WB = r_fault_wb;

endmodule

// File: doc/pipeline_mem_stage.md
Name: pipeline_mem_stage

Overview:
- Memory-access stage of the 5-stage RV64 pipeline. Sits directly downstream of the execution stage.
- Consumes the EX/MEM-latched ALU result, used as the effective address, plus store data and the decoded fields.
- Drives a req/ack data-memory port, performs byte-lane alignment and load extension, and registers the result into the MEM/WB boundary.
- Raises a stall to the hazard unit while a memory access is outstanding.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- ACK_TIMEOUT, 255, maximum cycles to wait for dmem_ack before aborting the access with a fault.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid_MEM  input  1  MEM slot holds a real instruction.
- alu_result_MEM  input  64  ALU result; effective address for loads/stores.
- reg_data2_MEM  input  64  store data (rs2).
- rd_MEM  input  5  destination register.
- opcode_MEM  input  7  opcode.
- funct3_MEM  input  3  access size/sign.
- dmem_req  output  1  memory request.
- dmem_we  output  1  1 = store.
- dmem_addr  output  64  doubleword-aligned address ({addr[63:3],3'b0}).
- dmem_wdata  output  64  lane-shifted store data.
- dmem_wstrb  output  8  byte enables.
- dmem_ack  input  1  request completed this cycle.
- dmem_rdata  input  64  doubleword read data; valid when dmem_ack=1.
- stall_MEM  output  1  freeze IF..MEM and hold EX/MEM stable.
- valid_WB  output  1  WB slot valid.
- rd_WB  output  5  destination register.
- reg_write_WB  output  1  write rd in WB.
- wb_data_WB  output  64  load data or ALU result.
- mem_fault_WB  output  1  misaligned, illegal funct3, or timeout.

Behaviour:
- Reset: state=IDLE, timeout counter=0. All *_WB outputs are 0. dmem_req=0 and stall_MEM=0 while reset is asserted.
- Classification:
  - LOAD = opcode 0000011.
  - STORE = opcode 0100011.
  - Anything else is a pass-through.
- Legal funct3: loads 000/001/010/011/100/101/110; stores 000–011.
- Misaligned when: half and addr[0]≠0; word and addr[1:0]≠0; double and addr[2:0]≠0.
- Fault op (misaligned or illegal funct3): no bus request. Next cycle valid_WB=1, mem_fault_WB=1, reg_write_WB=0. 1-cycle latency, no stall.
- Pass-through: next cycle valid_WB=1, wb_data_WB=alu_result. reg_write_WB=1 unless rd=0 or opcode ∈ {1100011 branch, 0001111 fence, 1110011 system}.
- Memory op FSM, states IDLE and WAIT:
  - dmem_req = valid legal mem op && (state==IDLE || state==WAIT).
  - stall_MEM = dmem_req && !dmem_ack.
  - IDLE: request issued. Ack in the same cycle (zero-wait) completes without entering WAIT; otherwise go to WAIT and clear the counter.
  - WAIT: request held; upstream holds its inputs stable. The counter increments each cycle.
  - On ack: the WB registers are loaded and state returns to IDLE.
  - When the counter reaches ACK_TIMEOUT with no ack: drop the request, write valid_WB=1 and mem_fault_WB=1, return to IDLE, deassert stall. A late ack after abort is ignored.
- Every stall cycle writes a bubble: valid_WB=0, reg_write_WB=0.
- Store lanes: off=addr[2:0]; dmem_wdata = reg_data2 << (8*off); dmem_wstrb = {1,3,15,255}[funct3] << off. A completed store sets reg_write_WB=0.
- Load extract: raw = dmem_rdata >> (8*off), then truncate to 8/16/32/64 bits and sign-extend (000/001/010) or zero-extend (100/101/110). 011 takes raw unchanged. reg_write_WB = (rd≠0).
- valid_MEM=0: no request, bubble written.
- Reset asserted mid-WAIT: state returns to IDLE immediately. The memory side must tolerate the abandoned request.

Decomposition:
- Shared package (rv_pkg):
  - opcode constants OP_LOAD, OP_STORE, OP_BRANCH, OP_FENCE, OP_SYSTEM.
  - funct3 encodings F3_B/H/W/D/BU/HU/WU.
  - FSM state enum.
- One natural sub-module: mem_lane_align. Purely combinational: store shift/strobe generation, load extract/extend, and misalign/illegal detection. The FSM, counter and WB registers stay in pipeline_mem_stage.

Test Plan:
- LW, addr 0x1004, rdata 0x80000000_12345678, ack zero-wait → no stall; next cycle wb_data_WB=0xFFFFFFFF_80000000, reg_write_WB=1.
- SB, addr 0x2003, rs2=0xAB, ack after 3 cycles → stall_MEM high 3 cycles with bubbles; dmem_wstrb=0x08, dmem_wdata=0xAB000000, dmem_addr=0x2000; then valid_WB=1, reg_write_WB=0.
- LH, addr 0x1001 → dmem_req never asserted; next cycle mem_fault_WB=1, reg_write_WB=0.
- LBU, addr 0x3007, rdata 0xF0000000_00000000 → wb_data_WB=0xF0.
- LD with ack withheld, ACK_TIMEOUT=4 → stall for the timeout window, then mem_fault_WB=1 and stall drops; an ack one cycle later produces no WB activity.
- LD in WAIT, reset pulsed → dmem_req=0, stall_MEM=0 and all WB outputs 0 immediately; the next ADD passes through with wb_data_WB=alu_result.
